// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-deep pending request so back-to-back frames need no idle cycle.
// Define UART_TX_ASSERT_EN to compile in simulation checks on the parameter and on the sampled byte.
module uart_transmitter #(
  parameter int ClocksPerBaud = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_byte_valid,
  output logic       tx_byte_done_out,
  output logic       tx_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int CntW = (ClocksPerBaud > 2) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(ClocksPerBaud - 1);

  state_t          tx_state;
  state_t          tx_state_next;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      data_reg;
  logic [7:0]      pend_byte;
  logic            pend_valid;
  logic            baud_last;
  logic            accept_idle;
  logic            accept_pend;

  assign baud_last = (baud_cnt == BaudLast);

  always_comb begin
    tx_state_next = tx_state;
    accept_idle   = 1'b0;
    accept_pend   = 1'b0;
    case (tx_state)
      IDLE: begin
        if (tx_byte_valid) begin
          accept_idle   = 1'b1;
          tx_state_next = START;
        end
      end
      START: begin
        if (baud_last) tx_state_next = DATA;
      end
      DATA: begin
        if (baud_last && (bit_idx == 3'd7)) tx_state_next = STOP;
      end
      STOP: begin
        // The final STOP cycle ignores requests so the pending decision is already registered.
        if (!baud_last && tx_byte_valid && !pend_valid) accept_pend = 1'b1;
        if (baud_last) tx_state_next = pend_valid ? START : IDLE;
      end
      default: tx_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if ((tx_state == IDLE) || baud_last) baud_cnt <= '0;
      else                                 baud_cnt <= baud_cnt + 1'b1;
      if ((tx_state == DATA) && baud_last) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg         <= '0;
      pend_byte        <= '0;
      pend_valid       <= 1'b0;
      tx_byte_done_out <= 1'b0;
    end else begin
      if (accept_idle) begin
        data_reg         <= tx_byte;
        tx_byte_done_out <= 1'b0;
      end
      if (accept_pend) begin
        pend_byte  <= tx_byte;
        pend_valid <= 1'b1;
      end
      if ((tx_state == STOP) && baud_last && pend_valid) begin
        data_reg         <= pend_byte;
        pend_valid       <= 1'b0;
        tx_byte_done_out <= 1'b0;
      end
      if ((tx_state == DATA) && baud_last && (bit_idx == 3'd7)) tx_byte_done_out <= 1'b1;
    end
  end

  // Line is driven from the current state, so it trails tx_state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_out <= 1'b1;
    end else begin
      case (tx_state)
        START:   tx_out <= 1'b0;
        DATA:    tx_out <= data_reg[bit_idx];
        default: tx_out <= 1'b1;
      endcase
    end
  end

`ifdef UART_TX_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ClocksPerBaud < 2)
        $error("uart_transmitter: ClocksPerBaud=%0d is below 2", ClocksPerBaud);
      if ((accept_idle || accept_pend) && $isunknown(tx_byte))
        $error("uart_transmitter: tx_byte has X/Z while a request is accepted");
    end
  end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: line monitor checks every frame against a queue of expected bytes.
module tb_uart_transmitter;
  localparam int CPB = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = '0;
  logic       tx_byte_valid = 1'b0;
  logic       tx_byte_done_out;
  logic       tx_out;

  uart_transmitter #(.ClocksPerBaud(CPB)) dut (
    .clk              (clk),
    .rst              (rst),
    .tx_byte          (tx_byte),
    .tx_byte_valid    (tx_byte_valid),
    .tx_byte_done_out (tx_byte_done_out),
    .tx_out           (tx_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  typedef struct {
    logic [7:0] data;
    int         rises;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    int         rises;
    int         lat;
  } vec_t;

  // Line monitor: frames start at the first low sample and span 10*CPB cycles.
  int         mon_cnt = 0;
  int         mon_rises;
  int         bitn;
  logic [7:0] mon_byte;
  logic       mon_prev;
  bit         mon_ok;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      mon_cnt = 0;
    end else if (mon_cnt == 0) begin
      if (tx_out === 1'b0) begin
        mon_cnt = 1; mon_byte = '0; mon_rises = 0; mon_prev = 1'b0; mon_ok = 1'b1;
      end
    end else begin
      bitn = mon_cnt / CPB;
      if (tx_out === 1'b1 && mon_prev === 1'b0) mon_rises++;
      if (bitn == 0) begin
        if (tx_out !== 1'b0) mon_ok = 1'b0;
      end else if (bitn <= 8) begin
        if (mon_cnt % CPB == 0) mon_byte[bitn-1] = tx_out;
        else if (tx_out !== mon_byte[bitn-1]) mon_ok = 1'b0;
      end else if (tx_out !== 1'b1) begin
        mon_ok = 1'b0;
      end
      mon_prev = tx_out;
      mon_cnt++;
      if (mon_cnt == 10 * CPB) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          check("frame_unexpected", int'(mon_byte), -1);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", int'(mon_byte), int'(e.data));
          check("frame_rises", mon_rises, e.rises);
          check("frame_shape", int'(mon_ok), 1);
        end
      end
    end
  end

  task automatic wait_state(input logic [1:0] target, input string name, output int unsigned at);
    at = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dut.tx_state == target) begin
        at = cyc;
        return;
      end
    end
    check({name, "_timeout"}, int'(dut.tx_state), int'(target));
  endtask

  task automatic wait_leave(input logic [1:0] s, output int unsigned at);
    at = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dut.tx_state != s) begin
        at = cyc;
        return;
      end
    end
    check("leave_timeout", int'(dut.tx_state), -1);
  endtask

  task automatic wait_done(output int unsigned at);
    at = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_byte_done_out === 1'b1) begin
        at = cyc;
        return;
      end
    end
    check("done_timeout", int'(tx_byte_done_out), 1);
  endtask

  // Caller is at a negedge with the block idle.
  task automatic send(input logic [7:0] b, input int rises,
                      output int unsigned t_start, output int unsigned t_low);
    tx_byte       = b;
    tx_byte_valid = 1'b1;
    exp_q.push_back('{data: b, rises: rises});
    wait_state(2'b01, "accept", t_start);
    tx_byte_valid = 1'b0;
    check("done_cleared", int'(tx_byte_done_out), 0);
    check("tx_out_lag", int'(tx_out), 1);
    @(negedge clk);
    check("tx_out_start", int'(tx_out), 0);
    t_low = cyc;
  endtask

  vec_t        vecs[5];
  int unsigned t_start, t_low, t_done, t_stop, t_leave;
  int          n;

  initial begin
    vecs[0] = '{data: 8'h00, rises: 1, lat: 9 * CPB};
    vecs[1] = '{data: 8'hFF, rises: 1, lat: 9 * CPB};
    vecs[2] = '{data: 8'hA5, rises: 4, lat: 9 * CPB};
    vecs[3] = '{data: 8'h01, rises: 2, lat: 9 * CPB};
    vecs[4] = '{data: 8'h80, rises: 1, lat: 9 * CPB};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_out", int'(tx_out), 1);
    check("rst_done", int'(tx_byte_done_out), 0);
    check("rst_state", int'(dut.tx_state), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_tx_out", int'(tx_out), 1);
      check("idle_done", int'(tx_byte_done_out), 0);
    end

    send(8'h55, 5, t_start, t_low);
    wait_done(t_done);
    check("done_latency_55", int'(t_done - t_start), 9 * CPB);
    check("done_in_stop", int'(dut.tx_state), 3);
    wait_state(2'b00, "idle_55", t_stop);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, vecs[i].rises, t_start, t_low);
      wait_done(t_done);
      check("done_latency_vec", int'(t_done - t_start), vecs[i].lat);
      wait_state(2'b00, "idle_vec", t_stop);
      @(negedge clk);
    end

    // Early back-to-back: second byte offered on the first STOP cycle.
    send(8'h55, 5, t_start, t_low);
    wait_state(2'b11, "stop_early", t_stop);
    tx_byte = 8'hAA;
    tx_byte_valid = 1'b1;
    exp_q.push_back('{data: 8'hAA, rises: 4});
    @(negedge clk);
    tx_byte_valid = 1'b0;
    wait_leave(2'b11, t_leave);
    check("b2b_direct_start", int'(dut.tx_state), 1);
    check("b2b_frame_len", int'(t_leave - t_low), 10 * CPB - 1);
    check("b2b_done_cleared", int'(tx_byte_done_out), 0);
    wait_done(t_done);
    check("b2b_done_latency", int'(t_done - t_leave), 9 * CPB);
    wait_state(2'b00, "idle_b2b", t_stop);
    repeat (2) @(negedge clk);

    // Late back-to-back: offered on the final STOP cycle and held one more edge.
    send(8'h55, 5, t_start, t_low);
    wait_state(2'b11, "stop_late", t_stop);
    repeat (CPB - 1) @(negedge clk);
    tx_byte = 8'hAA;
    tx_byte_valid = 1'b1;
    exp_q.push_back('{data: 8'hAA, rises: 4});
    wait_leave(2'b11, t_leave);
    check("late_idle", int'(dut.tx_state), 0);
    @(negedge clk);
    tx_byte_valid = 1'b0;
    check("late_accept", int'(dut.tx_state), 1);
    wait_done(t_done);
    check("late_done_latency", int'(t_done - t_leave), 9 * CPB + 1);
    wait_state(2'b00, "idle_late", t_stop);
    repeat (2) @(negedge clk);

    // Reset during data bit 3 aborts the frame at once.
    send(8'h0F, 2, t_start, t_low);
    n = 0;
    while (!(dut.tx_state == 2'b10 && dut.bit_idx == 3'd3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit3", int'(dut.bit_idx), 3);
    rst = 1'b1;
    #1;
    check("abort_tx_out", int'(tx_out), 1);
    check("abort_state", int'(dut.tx_state), 0);
    check("abort_done", int'(tx_byte_done_out), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", int'(tx_out), 1);
    send(8'h3C, 2, t_start, t_low);
    wait_done(t_done);
    check("post_rst_latency", int'(t_done - t_start), 9 * CPB);
    wait_state(2'b00, "idle_post", t_stop);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter ClocksPerBaud, default 2, is the number of clk cycles per serial bit; legal values are >= 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 tx_byte  input  8  byte to transmit, sampled when a request is accepted.
REQ-005 tx_byte_valid  input  1  transmit request, level-sampled on each rising clk edge.
REQ-006 tx_byte_done_out  output  1  registered flag: the accepted byte's data bits are complete.
REQ-007 tx_out  output  1  registered serial line, idle high.
REQ-008 The block SHALL expose internal 2-bit signals tx_state and tx_state_next (next-state value) for bench probing.

Function
REQ-009 The 2-bit state machine SHALL use encodings IDLE=00, START=01, DATA=10, STOP=11.
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each ClocksPerBaud cycles long on tx_out.
REQ-011 In IDLE, tx_byte_valid=1 at an edge SHALL capture tx_byte, clear tx_byte_done_out and enter START on that edge.
REQ-012 tx_out SHALL be registered from state/bit data, lagging tx_state by exactly one cycle: tx_out falls one edge after tx_state becomes START.
REQ-013 Each state (START, each DATA bit, STOP) SHALL last exactly ClocksPerBaud cycles, counted by a baud counter that resets on every bit boundary.
REQ-014 A 3-bit bit index SHALL step 0..7 through DATA; after bit 7 completes, the state SHALL move DATA->STOP.
REQ-015 tx_byte_done_out SHALL be set on the same edge as the DATA->STOP transition and held high until the next accepted request clears it.
REQ-016 In STOP, tx_byte_valid=1 on any cycle except the final STOP cycle SHALL capture tx_byte into a pending register.
REQ-017 When a request is pending at the end of STOP, the state SHALL go STOP->START directly, with no idle cycle.
REQ-018 When no request is pending at the end of STOP, the state SHALL go STOP->IDLE.
REQ-019 tx_byte_valid during START or DATA, or in the final STOP cycle, SHALL be ignored; the requester holds valid until it is accepted.
REQ-020 From the first low cycle of tx_out to tx_state leaving STOP for a back-to-back frame SHALL be 10*ClocksPerBaud-1 cycles.
REQ-021 From entering START to tx_byte_done_out=1 SHALL be 9*ClocksPerBaud cycles.
REQ-022 A request arriving in the final STOP cycle and held one more cycle SHALL be accepted from IDLE, giving 9*ClocksPerBaud+1 cycles from leaving STOP to done.

Reset
REQ-023 While rst=1, the block SHALL hold: state=IDLE, tx_out=1, tx_byte_done_out=0, counters=0, pending cleared, and data registers=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously.
REQ-025 After reset deasserts, the block SHALL remain idle with tx_out=1 until a request arrives.

Configuration
REQ-026 Macro UART_TX_ASSERT_EN, when defined, SHALL compile in simulation checks: error if ClocksPerBaud<2, and error if tx_byte contains X/Z while an accepted tx_byte_valid is high.
REQ-027 Without UART_TX_ASSERT_EN, no checks are compiled and function is identical.

Verification
REQ-028 Idle: reset for 2 cycles then release, no valid for 10 cycles -> tx_out=1 and tx_byte_done_out=0 throughout.
REQ-029 Single byte 0x55 with ClocksPerBaud=2:
- stimulus: valid for 1 cycle;
- tx_out sequence: 0, 1,0,1,0,1,0,1,0, 1, each 2 cycles;
- done=0 just after acceptance, done=1 at DATA->STOP.
REQ-030 Early back-to-back: 0xAA presented one cycle into STOP after 0x55 ->
- STOP->START directly;
- first frame = 10*CPB-1 cycles;
- second start-to-done = 9*CPB cycles;
- 0xAA shows four 0-1 transitions.
REQ-031 Late back-to-back: 0xAA presented on the final STOP cycle and held 2 edges -> one IDLE cycle, then second frame done after 9*CPB+1 cycles.
REQ-032 Reset mid-DATA: assert rst during bit 3 -> tx_out=1, state=IDLE, done=0 immediately, and the next request gives a full clean frame.
